// File: rtl/if_id_queue_if.sv
// Fetch-response channel between the AXI fetch path and the IF/ID queue.
// Valid/ready handshake plus the almost-full throttle back to PC.
interface if_id_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 32
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic [EXC_W-1:0]  if_excepttype;
  logic              if_epoch;
  logic              if_ready;
  logic              if_afull;

  modport master (
    output if_valid, if_pc, if_inst,
    output if_excepttype, if_epoch,
    input  if_ready, if_afull
  );

  modport slave (
    input  if_valid, if_pc, if_inst,
    input  if_excepttype, if_epoch,
    output if_ready, if_afull
  );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction queue with epoch-based wrong-path drop
// and delay-slot retention across branch redirects.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int AFULL  = 2,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 32,
  localparam int CW = $clog2(DEPTH+1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_id,
  if_id_queue_if.slave      fetch,
  input  logic              branch_redirect,
  input  logic              id_next_in_delay_slot,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [EXC_W-1:0]  id_excepttype,
  output logic              id_valid,
  output logic              id_in_delay_slot,
  output logic              stallreq_for_if,
  output logic [CW-1:0]     count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [EXC_W-1:0]  exc;
    logic              ds;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        id_q, id_d, head, wr_ent;
  logic          id_valid_q, id_valid_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          epoch_q, epoch_d;
  logic          ds_pend_q, ds_pend_d;
  logic          ds_next_q, ds_next_d;

  logic full, empty, acc, pop, bypass;
  logic hold_slot, slot_wr, push, ds_eff;

  assign full   = count_q == CW'(DEPTH);
  assign empty  = count_q == '0;
  assign acc    = fetch.if_valid && !full && !flush
               && (fetch.if_epoch == epoch_q);
  assign pop    = !stall_id && !empty;
  assign bypass = !stall_id && empty && acc;

  // A redirect with a non-empty queue keeps the head as the delay slot.
  assign hold_slot = branch_redirect && !empty;
  assign slot_wr   = acc && !hold_slot
                  && (ds_pend_q || (branch_redirect && empty));
  assign push      = acc && !bypass && !hold_slot;
  assign ds_eff    = ds_next_q || id_next_in_delay_slot;

  assign head   = mem_q[rd_q];
  assign wr_ent = '{pc:   fetch.if_pc,
                    inst: fetch.if_inst,
                    exc:  fetch.if_excepttype,
                    ds:   slot_wr};

  assign fetch.if_ready  = !full;
  assign fetch.if_afull  = count_q >= CW'(DEPTH-AFULL);
  assign stallreq_for_if = empty && !acc;

  assign id_pc            = id_q.pc;
  assign id_inst          = id_q.inst;
  assign id_excepttype    = id_q.exc;
  assign id_in_delay_slot = id_q.ds;
  assign id_valid         = id_valid_q;
  assign count            = count_q;

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    epoch_d    = epoch_q;
    ds_pend_d  = ds_pend_q;
    ds_next_d  = ds_next_q;
    id_d       = id_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      epoch_d    = !epoch_q;
      ds_pend_d  = 1'b0;
      ds_next_d  = 1'b0;
      id_d       = '0;
      id_valid_d = 1'b0;
    end else begin
      if (pop) rd_d = rd_q + PW'(1);
      if (hold_slot) begin
        wr_d      = rd_q + PW'(1);
        count_d   = pop ? '0 : CW'(1);
        epoch_d   = !epoch_q;
        ds_pend_d = 1'b0;
      end else begin
        if (push) wr_d = wr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
      end
      if (slot_wr) begin
        epoch_d   = !epoch_q;
        ds_pend_d = 1'b0;
      end else if (branch_redirect && empty) begin
        ds_pend_d = 1'b1;
      end
      if (!stall_id) begin
        if (pop || bypass) begin
          id_d       = pop ? head : wr_ent;
          id_d.ds    = id_d.ds | ds_eff;
          id_valid_d = 1'b1;
          ds_next_d  = 1'b0;
        end else begin
          id_d       = '0;
          id_valid_d = 1'b0;
          ds_next_d  = ds_eff;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && push) mem_q[wr_q] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      epoch_q    <= 1'b0;
      ds_pend_q  <= 1'b0;
      ds_next_q  <= 1'b0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      epoch_q    <= epoch_d;
      ds_pend_q  <= ds_pend_d;
      ds_next_q  <= ds_next_d;
      id_q       <= id_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-level reference model checked every
// cycle, plus hand-computed expectations along the directed scenarios.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int AFULL = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          stall_id = 1'b0;
  logic          branch_redirect = 1'b0;
  logic          nids = 1'b0;
  logic [31:0]   id_pc, id_inst, id_excepttype;
  logic          id_valid, id_in_delay_slot, stallreq_for_if;
  logic [CW-1:0] count;

  if_id_queue_if #(.ADDR_W(32), .INST_W(32), .EXC_W(32)) fetch ();

  if_id_queue #(
    .DEPTH(DEPTH), .AFULL(AFULL),
    .ADDR_W(32), .INST_W(32), .EXC_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .stall_id(stall_id),
    .fetch(fetch),
    .branch_redirect(branch_redirect),
    .id_next_in_delay_slot(nids),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_excepttype(id_excepttype),
    .id_valid(id_valid),
    .id_in_delay_slot(id_in_delay_slot),
    .stallreq_for_if(stallreq_for_if),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
    bit          ds;
  } ent_t;

  ent_t mq[$];
  ent_t m_id;
  bit   m_idv, m_epoch, m_dsp, m_dsn;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] exc_of(logic [31:0] pc);
    return pc >> 4;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit m_acc();
    return fetch.if_valid && !flush && (mq.size() < DEPTH)
        && (fetch.if_epoch == m_epoch);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_id    = '{pc: 0, inst: 0, exc: 0, ds: 0};
    m_idv   = 0;
    m_epoch = 0;
    m_dsp   = 0;
    m_dsn   = 0;
  endtask

  // Advance the model by one clock using the inputs presently applied.
  task automatic m_step();
    bit   acc, keep, slot, dse;
    ent_t e;
    acc  = m_acc();
    keep = acc;
    slot = 0;
    if (flush) begin
      mq.delete();
      m_id    = '{pc: 0, inst: 0, exc: 0, ds: 0};
      m_idv   = 0;
      m_dsn   = 0;
      m_dsp   = 0;
      m_epoch = !m_epoch;
      return;
    end
    if (branch_redirect && mq.size() > 0) begin
      while (mq.size() > 1) void'(mq.pop_back());
      keep    = 0;
      m_epoch = !m_epoch;
      m_dsp   = 0;
    end else if ((branch_redirect || m_dsp) && acc) begin
      slot    = 1;
      m_epoch = !m_epoch;
      m_dsp   = 0;
    end else if (branch_redirect) begin
      m_dsp = 1;
    end
    if (keep) begin
      e = '{pc: fetch.if_pc, inst: fetch.if_inst,
            exc: fetch.if_excepttype, ds: slot};
      mq.push_back(e);
    end
    if (!stall_id) begin
      dse = m_dsn || nids;
      if (mq.size() > 0) begin
        m_id    = mq.pop_front();
        m_id.ds = m_id.ds | dse;
        m_idv   = 1;
        m_dsn   = 0;
      end else begin
        m_id  = '{pc: 0, inst: 0, exc: 0, ds: 0};
        m_idv = 0;
        m_dsn = dse;
      end
    end
  endtask

  task automatic compare();
    chk("count", 64'(count), 64'(mq.size()));
    chk("id_valid", 64'(id_valid), 64'(m_idv));
    chk("id_pc", 64'(id_pc), 64'(m_id.pc));
    chk("id_inst", 64'(id_inst), 64'(m_id.inst));
    chk("id_exc", 64'(id_excepttype), 64'(m_id.exc));
    chk("id_ds", 64'(id_in_delay_slot), 64'(m_id.ds));
    chk("if_ready", 64'(fetch.if_ready), 64'(mq.size() < DEPTH));
    chk("if_afull", 64'(fetch.if_afull),
        64'(mq.size() >= DEPTH - AFULL));
    chk("stallreq", 64'(stallreq_for_if),
        64'((mq.size() == 0) && !m_acc()));
  endtask

  task automatic cyc();
    if (!rst) m_reset();
    else m_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic push(logic [31:0] pc, logic ep);
    fetch.if_valid      = 1'b1;
    fetch.if_pc         = pc;
    fetch.if_inst       = inst_of(pc);
    fetch.if_excepttype = exc_of(pc);
    fetch.if_epoch      = ep;
    cyc();
    fetch.if_valid = 1'b0;
  endtask

  initial begin
    fetch.if_valid      = 1'b0;
    fetch.if_pc         = '0;
    fetch.if_inst       = '0;
    fetch.if_excepttype = '0;
    fetch.if_epoch      = 1'b0;
    m_reset();

    cyc();
    cyc();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fetch.if_ready), 64'd1);
    chk("rst_stallreq", 64'(stallreq_for_if), 64'd1);
    chk("rst_afull", 64'(fetch.if_afull), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    rst = 1'b1;
    cyc();

    // Fill while stalled, then drain.
    stall_id = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(fetch.if_ready), 64'd0);
    push(32'h110, 1'b0);
    chk("full_drop", 64'(count), 64'd4);
    stall_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_pc", 64'(id_pc), 64'(32'h100 + 32'(4*i)));
    end
    cyc();
    chk("drain_bubble", 64'(id_valid), 64'd0);
    chk("drain_pc0", 64'(id_pc), 64'd0);

    // Bypass and simultaneous push/pop.
    push(32'h200, 1'b0);
    chk("byp_pc", 64'(id_pc), 64'h200);
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_inst", 64'(id_inst), 64'(32'hDEAD_0200));
    stall_id = 1'b1;
    push(32'h210, 1'b0);
    push(32'h214, 1'b0);
    stall_id = 1'b0;
    push(32'h218, 1'b0);
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_pc", 64'(id_pc), 64'h210);
    cyc();
    cyc();
    chk("pp_last", 64'(id_pc), 64'h218);
    cyc();

    // Redirect with the delay slot already queued.
    push(32'h300, 1'b0);
    stall_id = 1'b1;
    push(32'h304, 1'b0);
    push(32'h308, 1'b0);
    push(32'h30C, 1'b0);
    stall_id = 1'b0;
    nids = 1'b1;
    branch_redirect = 1'b1;
    cyc();
    nids = 1'b0;
    branch_redirect = 1'b0;
    chk("rq_pc", 64'(id_pc), 64'h304);
    chk("rq_ds", 64'(id_in_delay_slot), 64'd1);
    chk("rq_count", 64'(count), 64'd0);
    push(32'h310, 1'b0);
    chk("rq_drop", 64'(id_valid), 64'd0);

    // Redirect with an empty queue: slot arrives later.
    push(32'h400, 1'b1);
    nids = 1'b1;
    branch_redirect = 1'b1;
    cyc();
    nids = 1'b0;
    branch_redirect = 1'b0;
    chk("re_bubble", 64'(id_valid), 64'd0);
    push(32'h404, 1'b1);
    chk("re_pc", 64'(id_pc), 64'h404);
    chk("re_ds", 64'(id_in_delay_slot), 64'd1);
    push(32'h408, 1'b1);
    chk("re_drop", 64'(id_valid), 64'd0);
    push(32'h500, 1'b0);
    chk("re_new", 64'(id_pc), 64'h500);
    chk("re_new_ds", 64'(id_in_delay_slot), 64'd0);

    // Flush with a write in the same cycle.
    stall_id = 1'b1;
    push(32'h600, 1'b0);
    push(32'h604, 1'b0);
    push(32'h608, 1'b0);
    chk("fl_pre", 64'(count), 64'd3);
    stall_id = 1'b0;
    flush = 1'b1;
    push(32'h60C, 1'b0);
    flush = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(id_valid), 64'd0);
    push(32'h700, 1'b0);
    chk("fl_drop", 64'(id_valid), 64'd0);
    push(32'h704, 1'b1);
    chk("fl_new", 64'(id_pc), 64'h704);

    // Asynchronous reset in the middle of a stream.
    stall_id = 1'b1;
    push(32'h800, 1'b1);
    push(32'h804, 1'b1);
    push(32'h808, 1'b1);
    chk("mr_pre", 64'(count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_valid", 64'(id_valid), 64'd0);
    chk("mr_inst", 64'(id_inst), 64'd0);
    chk("mr_ready", 64'(fetch.if_ready), 64'd1);
    cyc();
    rst = 1'b1;
    stall_id = 1'b0;
    push(32'h900, 1'b0);
    chk("mr_after", 64'(id_pc), 64'h900);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
